// File: rtl/out_flits_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : out_flits_buffer_pkg
// Purpose : Shared NIC flit definitions plus the transmit buffer FSM encoding.
//           The NIC-wide macros are guarded so that a project-level copy of
//           the defines file takes precedence when it is compiled first.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`ifndef NIC_DEFINES_V
`define NIC_DEFINES_V
`define FLIT_WIDTH        16
`define MAX_PACKET_LENGHT 8
`define FLIT_TYPE_BITS    2
`define FLIT_TYPE_BODY      2'b00
`define FLIT_TYPE_HEAD      2'b01
`define FLIT_TYPE_TAIL      2'b10
`define FLIT_TYPE_HEAD_TAIL 2'b11
`define N_ROUTER_CREDITS  4
`endif

package out_flits_buffer_pkg;

  // One-hot state encodings.
  localparam logic [2:0] ST_IDLE      = 3'b001;
  localparam logic [2:0] ST_SENDING   = 3'b010;
  localparam logic [2:0] ST_WAIT_FREE = 3'b100;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    SENDING   = ST_SENDING,
    WAIT_FREE = ST_WAIT_FREE
  } ofb_state_t;

endpackage : out_flits_buffer_pkg
`default_nettype wire

// File: rtl/out_flits_buffer_credit_counter.sv
`default_nettype none
// ============================================================================
// Module  : credit_counter
// Purpose : Tracks free slots in the router input buffer. Starts full,
//           saturates at N_CREDITS, and a simultaneous inc/dec cancels out.
// Ports   : clk, rst (async, active-low), inc (credit returned),
//           dec (flit sent), cnt_o (current count), has_credit_o (cnt != 0)
// Revision: 1.0 - initial release
// ============================================================================
module credit_counter #(
  parameter int N_CREDITS     = 4,
  parameter int N_BITS_CREDIT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     dec,
  output logic [N_BITS_CREDIT-1:0] cnt_o,
  output logic                     has_credit_o
);

  localparam logic [N_BITS_CREDIT-1:0] MAX_CNT = N_BITS_CREDIT'(N_CREDITS);

  logic [N_BITS_CREDIT-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= MAX_CNT;
    end else if (inc && !dec) begin
      // Surplus credits beyond the buffer depth are dropped.
      if (cnt != MAX_CNT) cnt <= cnt + N_BITS_CREDIT'(1);
    end else if (dec && !inc) begin
      // dec is only raised while cnt != 0, so no underflow guard is needed.
      cnt <= cnt - N_BITS_CREDIT'(1);
    end
  end

  assign cnt_o        = cnt;
  assign has_credit_o = (cnt != '0);

endmodule : credit_counter
`default_nettype wire

// File: rtl/out_flits_buffer.sv
`default_nettype none
// ============================================================================
// Module  : out_flits_buffer
// Purpose : NIC transmit flits buffer. Captures one whole packet from the
//           message-to-packet stage on a request/grant handshake, then sends
//           it flit by flit to the router under credit-based flow control.
//           After a tail the block waits for the router's free pulse before
//           accepting the next packet (atomic buffer allocation).
// Ports   : clk, rst (async, active-low)
//           r_msg_to_pkt_i / g_msg_to_pkt_o : packet request / grant
//           in_link_i, in_sel_i             : parallel packet and valid mask
//           out_link_o, is_valid_o          : registered flit toward router
//           credit_signal_i, free_signal_i  : router flow-control feedback
// Revision: 1.0 - initial release
// ============================================================================
module out_flits_buffer
  import out_flits_buffer_pkg::*;
#(
  parameter int N_BITS_POINTER = 3,
  parameter int N_CREDITS      = `N_ROUTER_CREDITS,
  parameter int N_BITS_CREDIT  = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       r_msg_to_pkt_i,
  output logic                                       g_msg_to_pkt_o,
  input  logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]  in_link_i,
  input  logic [`MAX_PACKET_LENGHT-1:0]              in_sel_i,
  output logic [`FLIT_WIDTH-1:0]                     out_link_o,
  output logic                                       is_valid_o,
  input  logic                                       credit_signal_i,
  input  logic                                       free_signal_i
);

  localparam int MAX_LEN = `MAX_PACKET_LENGHT;
  localparam int FW      = `FLIT_WIDTH;

  ofb_state_t                state;
  logic [FW-1:0]             pkt_r [MAX_LEN];
  logic [MAX_LEN-1:0]        sel_r;
  logic [N_BITS_POINTER-1:0] idx_r;
  logic [N_BITS_POINTER-1:0] last_r;
  logic [N_BITS_CREDIT-1:0]  credit_cnt;
  logic                      has_credit;
  logic                      grant;
  logic                      send;

  assign grant          = (state == IDLE) && r_msg_to_pkt_i;
  assign g_msg_to_pkt_o = grant;
  // Only the registered count gates a send; a credit arriving this cycle
  // becomes usable on the next one.
  assign send           = (state == SENDING) && has_credit;

  // Index of the highest valid flit. Derived from the captured mask, so it
  // is stable for the whole packet and resets to 0 with the mask.
  always_comb begin
    last_r = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (sel_r[i]) last_r = N_BITS_POINTER'(i);
    end
  end

  credit_counter #(
    .N_CREDITS     (N_CREDITS),
    .N_BITS_CREDIT (N_BITS_CREDIT)
  ) u_credit_counter (
    .clk          (clk),
    .rst          (rst),
    .inc          (credit_signal_i),
    .dec          (send),
    .cnt_o        (credit_cnt),
    .has_credit_o (has_credit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel_r      <= '0;
      idx_r      <= '0;
      out_link_o <= '0;
      is_valid_o <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) pkt_r[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          is_valid_o <= 1'b0;
          if (grant) begin
            for (int i = 0; i < MAX_LEN; i++) pkt_r[i] <= in_link_i[i*FW +: FW];
            sel_r <= in_sel_i;
            idx_r <= '0;
            // An empty mask consumes the request without sending anything.
            if (in_sel_i != '0) state <= SENDING;
          end
        end
        SENDING: begin
          if (send) begin
            out_link_o <= pkt_r[idx_r];
            is_valid_o <= 1'b1;
            idx_r      <= idx_r + N_BITS_POINTER'(1);
            if (idx_r == last_r) state <= WAIT_FREE;
          end else begin
            is_valid_o <= 1'b0;
          end
        end
        WAIT_FREE: begin
          is_valid_o <= 1'b0;
          if (free_signal_i) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          is_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : out_flits_buffer
`default_nettype wire

// File: tb/tb_out_flits_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_out_flits_buffer
// Purpose : Self-checking bench for out_flits_buffer. Instance A uses the
//           default 4 credits, instance B only 2 credits. Expected flits are
//           queued when a packet is offered and checked as they appear.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef NIC_DEFINES_V
`define NIC_DEFINES_V
`define FLIT_WIDTH        16
`define MAX_PACKET_LENGHT 8
`define FLIT_TYPE_BITS    2
`define FLIT_TYPE_BODY      2'b00
`define FLIT_TYPE_HEAD      2'b01
`define FLIT_TYPE_TAIL      2'b10
`define FLIT_TYPE_HEAD_TAIL 2'b11
`define N_ROUTER_CREDITS  4
`endif

module tb_out_flits_buffer;

  localparam int ML = `MAX_PACKET_LENGHT;
  localparam int FW = `FLIT_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic             req = 0, credit = 0, free_s = 0;
  logic [ML*FW-1:0] in_link = '0;
  logic [ML-1:0]    in_sel = '0;
  logic             grant, is_valid;
  logic [FW-1:0]    out_link;

  // Instance B signals
  logic             b_req = 0, b_credit = 0, b_free = 0;
  logic [ML*FW-1:0] b_in_link = '0;
  logic [ML-1:0]    b_in_sel = '0;
  logic             b_grant, b_is_valid;
  logic [FW-1:0]    b_out_link;

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] qa[$];
  logic [FW-1:0] qb[$];

  out_flits_buffer dut (
    .clk(clk), .rst(rst),
    .r_msg_to_pkt_i(req), .g_msg_to_pkt_o(grant),
    .in_link_i(in_link), .in_sel_i(in_sel),
    .out_link_o(out_link), .is_valid_o(is_valid),
    .credit_signal_i(credit), .free_signal_i(free_s)
  );

  out_flits_buffer #(.N_BITS_POINTER(3), .N_CREDITS(2), .N_BITS_CREDIT(2)) dut_b (
    .clk(clk), .rst(rst),
    .r_msg_to_pkt_i(b_req), .g_msg_to_pkt_o(b_grant),
    .in_link_i(b_in_link), .in_sel_i(b_in_sel),
    .out_link_o(b_out_link), .is_valid_o(b_is_valid),
    .credit_signal_i(b_credit), .free_signal_i(b_free)
  );

  // Scoreboard monitors: every valid flit must match the oldest expected one.
  always @(negedge clk) begin
    if (is_valid === 1'b1) begin
      n_checks++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_flit: got %h, required no valid flit", out_link);
      end else begin
        logic [FW-1:0] e;
        e = qa.pop_front();
        if (out_link !== e) begin
          n_fail++;
          $display("FAIL a_flit_data: got %h, required %h", out_link, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_is_valid === 1'b1) begin
      n_checks++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_flit: got %h, required no valid flit", b_out_link);
      end else begin
        logic [FW-1:0] e;
        e = qb.pop_front();
        if (b_out_link !== e) begin
          n_fail++;
          $display("FAIL b_flit_data: got %h, required %h", b_out_link, e);
        end
      end
    end
  end

  // Packet of len flits with proper type bits; flits past len carry junk
  // that must never be transmitted.
  task automatic build(input int len, input int base,
                       output logic [ML*FW-1:0] link, output logic [ML-1:0] sel);
    logic [1:0] t;
    link = '0;
    sel  = '0;
    for (int i = 0; i < ML; i++) begin
      if (len == 1)          t = `FLIT_TYPE_HEAD_TAIL;
      else if (i == 0)       t = `FLIT_TYPE_HEAD;
      else if (i == len - 1) t = `FLIT_TYPE_TAIL;
      else                   t = `FLIT_TYPE_BODY;
      link[i*FW +: FW] = {t, 14'(base + i * 17)};
      if (i < len) sel[i] = 1'b1;
    end
  endtask

  task automatic push_a(input int len);
    for (int i = 0; i < len; i++) qa.push_back(in_link[i*FW +: FW]);
  endtask

  task automatic push_b(input int len);
    for (int i = 0; i < len; i++) qb.push_back(b_in_link[i*FW +: FW]);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (is_valid !== 1'b0 || out_link !== '0 || grant !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b link=%h grant=%b, required 0/0/0",
               is_valid, out_link, grant);
    end
    n_checks++;
    if (dut.credit_cnt !== 3'd4 || dut_b.credit_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_credits: got a=%0d b=%0d, required 4/2",
               dut.credit_cnt, dut_b.credit_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_flit;
    build(1, 14'h100, in_link, in_sel);
    push_a(1);
    req = 1'b1;
    #1;
    n_checks++;
    if (grant !== 1'b1) begin n_fail++; $display("FAIL single_grant: got %b, required 1", grant); end
    @(negedge clk);
    req = 1'b0;
    n_checks++;
    if (is_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid=%b, required 0", is_valid); end
    @(negedge clk);
    n_checks++;
    if (is_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, required 1", is_valid); end
    // Now in WAIT_FREE: a new request must be refused.
    build(4, 14'h200, in_link, in_sel);
    req = 1'b1;
    repeat (2) begin
      #1;
      n_checks++;
      if (grant !== 1'b0) begin n_fail++; $display("FAIL wait_free_no_grant: got %b, required 0", grant); end
      @(negedge clk);
    end
    credit = 1'b1;
    @(negedge clk);
    credit = 1'b0;
    n_checks++;
    if (dut.credit_cnt !== 3'd4) begin n_fail++; $display("FAIL credit_return: got %0d, required 4", dut.credit_cnt); end
  endtask

  task automatic test_four_flits;
    free_s = 1'b1;
    @(negedge clk);
    free_s = 1'b0;
    push_a(4);
    #1;
    n_checks++;
    if (grant !== 1'b1) begin n_fail++; $display("FAIL four_grant_after_free: got %b, required 1", grant); end
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (is_valid !== 1'b1) begin n_fail++; $display("FAIL four_back_to_back[%0d]: got %b, required 1", i, is_valid); end
    end
    @(negedge clk);
    n_checks++;
    if (is_valid !== 1'b0 || dut.credit_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL four_end: got valid=%b cnt=%0d, required 0/0", is_valid, dut.credit_cnt);
    end
  endtask

  task automatic test_back_to_back;
    credit = 1'b1;
    repeat (4) @(negedge clk);
    credit = 1'b0;
    free_s = 1'b1;
    @(negedge clk);
    free_s = 1'b0;
    n_checks++;
    if (dut.credit_cnt !== 3'd4) begin n_fail++; $display("FAIL refill: got %0d, required 4", dut.credit_cnt); end
    build(4, 14'h300, in_link, in_sel);
    push_a(4);
    req = 1'b1;
    #1;
    n_checks++;
    if (grant !== 1'b1) begin n_fail++; $display("FAIL b2b_grant: got %b, required 1", grant); end
    @(negedge clk);
    req = 1'b0;
    credit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (is_valid !== 1'b1 || dut.credit_cnt !== 3'd4) begin
        n_fail++;
        $display("FAIL b2b_send_and_credit[%0d]: got valid=%b cnt=%0d, required 1/4",
                 i, is_valid, dut.credit_cnt);
      end
    end
    repeat (3) @(negedge clk);
    credit = 1'b0;
    n_checks++;
    if (dut.credit_cnt !== 3'd4 || is_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_saturate: got cnt=%0d valid=%b, required 4/0", dut.credit_cnt, is_valid);
    end
  endtask

  task automatic test_empty_mask;
    free_s = 1'b1;
    @(negedge clk);
    free_s = 1'b0;
    in_sel = '0;
    req = 1'b1;
    #1;
    n_checks++;
    if (grant !== 1'b1) begin n_fail++; $display("FAIL empty_grant: got %b, required 1", grant); end
    @(negedge clk);
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (is_valid !== 1'b0) begin n_fail++; $display("FAIL empty_no_valid: got %b, required 0", is_valid); end
    end
    req = 1'b1;
    #1;
    n_checks++;
    if (grant !== 1'b1) begin n_fail++; $display("FAIL empty_stays_idle: got grant=%b, required 1", grant); end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset_mid_packet;
    build(4, 14'h400, in_link, in_sel);
    push_a(4);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (is_valid !== 1'b0 || dut.credit_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_mid_packet: got valid=%b cnt=%0d, required 0/4", is_valid, dut.credit_cnt);
    end
    n_checks++;
    if (qa.size() != 2) begin
      n_fail++;
      $display("FAIL reset_mid_flits_seen: got %0d pending, required 2", qa.size());
    end
    qa.delete();
    @(negedge clk);
    rst = 1'b1;
    build(2, 14'h500, in_link, in_sel);
    push_a(2);
    req = 1'b1;
    #1;
    n_checks++;
    if (grant !== 1'b1) begin n_fail++; $display("FAIL post_reset_grant: got %b, required 1", grant); end
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL post_reset_packet: got %0d pending, required 0", qa.size()); end
  endtask

  task automatic test_two_credits;
    build(4, 14'h600, b_in_link, b_in_sel);
    push_b(4);
    b_req = 1'b1;
    #1;
    n_checks++;
    if (b_grant !== 1'b1) begin n_fail++; $display("FAIL b_grant: got %b, required 1", b_grant); end
    @(negedge clk);
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (b_is_valid !== 1'b1) begin n_fail++; $display("FAIL b_flit1_valid: got %b, required 1", b_is_valid); end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (b_is_valid !== 1'b0 || dut_b.credit_cnt !== 2'd0) begin
        n_fail++;
        $display("FAIL b_stall: got valid=%b cnt=%0d, required 0/0", b_is_valid, dut_b.credit_cnt);
      end
    end
    for (int k = 0; k < 2; k++) begin
      b_credit = 1'b1;
      @(negedge clk);
      b_credit = 1'b0;
      n_checks++;
      if (b_is_valid !== 1'b0) begin n_fail++; $display("FAIL b_credit_same_cycle[%0d]: got %b, required 0", k, b_is_valid); end
      @(negedge clk);
      n_checks++;
      if (b_is_valid !== 1'b1) begin n_fail++; $display("FAIL b_credit_send[%0d]: got %b, required 1", k, b_is_valid); end
    end
    @(negedge clk);
    n_checks++;
    if (b_is_valid !== 1'b0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL b_done: got valid=%b pending=%0d, required 0/0", b_is_valid, qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_four_flits();
    test_back_to_back();
    test_empty_mask();
    test_reset_mid_packet();
    test_two_credits();
    @(negedge clk);
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL final_queues: got a=%0d b=%0d pending, required 0/0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_out_flits_buffer
`default_nettype wire
